irq_reset_ctrl: RTL
===================

Name: irq_reset_ctrl

Overview:
Parametrised CPU system-control block: a CPU reset generator plus an N-source interrupt priority encoder driving the 68000 IPL lines. It generalises the fixed two-source VIA/SCC encoding to any number of sources. Each source has a per-source priority level and a per-source level or edge mode. Edge-mode sources latch a pending bit that is cleared by an interrupt-acknowledge handshake. Sits between the peripheral IRQ outputs and the CPU core inside the data controller.

Parameters:
N_SRC, 4, number of interrupt sources (1..8)
RST_W, 20, width of reset delay counter
RST_CYCLES, 20'hFFFFF, reset hold length in cep ticks; must be nonzero
SRC_LEVELS, {3'd1,3'd4,3'd5,3'd6}, packed 3*N_SRC bits; bits [3i+2:3i] = IPL level of source i; level 0 = source disabled
EDGE_MASK, 4'b0000, bit i = 1: source i is falling-edge latched; 0: level-sensitive

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cep  in  1  clock-enable tick (CPU phase)
_irq_src  in  N_SRC  active-low interrupt requests, asynchronous to clk
iack  in  1  one-clk strobe: CPU interrupt-acknowledge cycle
iack_level  in  3  level being acknowledged (valid with iack)
_cpuReset  out  1  active-low CPU reset
_cpuIPL  out  3  active-low encoded interrupt level
pending  out  N_SRC  current pending bit per source (active high)
active_src  out  3  index of the lowest-numbered source at the winning level; 0 when none

Behaviour:
- Reset state (reset high): counter = RST_CYCLES; _cpuReset = 0; _cpuIPL = 3'b111; pending = 0; active_src = 0; sync flops = all 1 (inactive).
- Reset counter: after reset falls, the counter decrements by 1 on each clk where cep = 1, and only while it is nonzero.
  - _cpuReset = (counter == 0), combinational from the counter register.
  - It therefore goes high on the clk after the RST_CYCLES-th cep.
  - The counter never wraps; it holds at 0.
- Synchroniser: each _irq_src bit passes through 2 flops on clk. Call the output s[i] (active high after inversion). s_d[i] is s[i] delayed one further clk.
- Pending, per clk:
  - While _cpuReset = 0: pending is forced to 0.
  - Level source: pending[i] <= s[i].
  - Edge source, set: s[i] & ~s_d[i].
  - Edge source, clear: iack & (iack_level == SRC_LEVELS[i]).
  - Set has priority over clear in the same clk; pending then stays 1.
  - A source whose SRC_LEVELS field is 0 always has pending = 0.
- Encoder: lvl = maximum SRC_LEVELS[i] over all i with pending[i] = 1; lvl = 0 when none are pending.
  - Sources at equal levels merge.
  - active_src = lowest index among pending sources with SRC_LEVELS[i] == lvl.
- Output register: on clk with cep = 1, _cpuIPL <= ~lvl and active_src <= winner. Both hold between cep ticks. While _cpuReset = 0 they are held at 3'b111 and 0.
- Latency, level source, cep every clk: _irq_src fall to _cpuIPL change = 4 clk (2 sync + 1 pending + 1 output). Edge source: same.
- iack has no effect on level sources; it must be removed at the peripheral.
- iack with no matching pending source is ignored.
- Reset asserted mid-operation: all state returns to reset values at once (asynchronous), and the full hold sequence restarts.

Optional Feature:
IPL_FILTER_EN
- Defined: _cpuIPL updates only when lvl has been equal on 2 consecutive cep ticks. This is a 3-bit last-sampled register compared on each cep.
  - A candidate changing every cep never propagates.
  - Latency grows by exactly 1 cep tick.
  - active_src follows the same qualification.
- Not defined: _cpuIPL updates on every cep as described above, with no sample register.

Test Plan:
1. RST_CYCLES = 16, cep high every 2nd clk, release reset -> _cpuReset low for exactly 32 clk, high from clk 33 on; _cpuIPL = 3'b111 throughout.
2. After reset, cep = 1: assert _irq_src[0] (level 6) and _irq_src[1] (level 5) together -> _cpuIPL = 3'b001 and active_src = 0 after 4 clk; release src0 -> 3'b010 and active_src = 1 after 4 clk; release src1 -> 3'b111.
3. EDGE_MASK = 4'b0100, src2 level 4: 1-clk-wide-at-sync low pulse on _irq_src[2] -> pending[2] = 1 persists, _cpuIPL = 3'b011. Then iack with iack_level = 3'd5 -> no change. Then iack with iack_level = 3'd4 -> pending[2] = 0 next clk, _cpuIPL = 3'b111 on the next cep.
4. Edge set and matching iack in the same clk -> pending[2] stays 1, and _cpuIPL stays 3'b011.
5. Source at level 0 held low -> pending bit stays 0 and _cpuIPL stays 3'b111. Assert reset while _cpuIPL = 3'b001 -> _cpuIPL = 3'b111 and _cpuReset = 0 asynchronously, and the hold restarts from RST_CYCLES.
6. IPL_FILTER_EN defined, cep = 1: src0 toggled every clk at the synchroniser output -> _cpuIPL never leaves 3'b111. Src0 held -> 3'b001 after 5 clk.

Source files
------------

// File: rtl/irq_reset_ctrl.sv
// irq_reset_ctrl: CPU reset generator plus N-source interrupt priority encoder
// driving the 68000 active-low IPL lines.
//
// Each source has its own IPL level (0 = disabled) and its own level/edge mode.
// Edge sources latch a pending bit, which an interrupt acknowledge of the
// matching level clears.
//
// Optional build macro: IPL_FILTER_EN. When it is defined, the IPL outputs
// change only after the winning level has been sampled equal on two
// consecutive cep ticks.
module irq_reset_ctrl #(
  parameter int unsigned        N_SRC      = 4,
  parameter int unsigned        RST_W      = 20,
  parameter logic [RST_W-1:0]   RST_CYCLES = 20'hFFFFF,
  parameter logic [3*N_SRC-1:0] SRC_LEVELS = {3'd1, 3'd4, 3'd5, 3'd6},
  parameter logic [N_SRC-1:0]   EDGE_MASK  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cep,
  input  logic [N_SRC-1:0] _irq_src,
  input  logic             iack,
  input  logic [2:0]       iack_level,
  output logic             _cpuReset,
  output logic [2:0]       _cpuIPL,
  output logic [N_SRC-1:0] pending,
  output logic [2:0]       active_src
);

  logic [RST_W-1:0] cnt_q, cnt_d;
  logic [N_SRC-1:0] sync1_q, sync2_q;   // raw active-low samples
  logic [N_SRC-1:0] sdly_q;             // active-high request, one clk later
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [2:0]       ipl_q, ipl_d;
  logic [2:0]       act_q, act_d;
`ifdef IPL_FILTER_EN
  logic [2:0]       samp_q, samp_d;
`endif

  logic             cpu_run;
  logic [N_SRC-1:0] s;
  logic [2:0]       lvl;
  logic [2:0]       win;

  assign cpu_run    = (cnt_q == '0);
  assign s          = ~sync2_q;
  assign _cpuReset  = cpu_run;
  assign _cpuIPL    = ipl_q;
  assign pending    = pend_q;
  assign active_src = act_q;

  // Reset hold counter: counts cep ticks down to zero and then sticks there.
  always_comb begin
    cnt_d = cnt_q;
    if (cep && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
  end

  // Pending bits: level sources follow the request; edge sources set on a rising
  // request and clear on a matching acknowledge, with set taking priority.
  always_comb begin
    pend_d = '0;
    if (cpu_run) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (SRC_LEVELS[3*i +: 3] != 3'd0) begin
          if (EDGE_MASK[i])
            pend_d[i] = (s[i] & ~sdly_q[i]) |
                        (pend_q[i] & ~(iack && (iack_level == SRC_LEVELS[3*i +: 3])));
          else
            pend_d[i] = s[i];
        end
      end
    end
  end

  // Priority encoder: highest pending level wins; a strict compare keeps the
  // lowest index among sources that share that level.
  always_comb begin
    lvl = 3'd0;
    win = 3'd0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (pend_q[i] && (SRC_LEVELS[3*i +: 3] > lvl)) begin
        lvl = SRC_LEVELS[3*i +: 3];
        win = 3'(i);
      end
    end
  end

  // Output register: loads on cep ticks and is parked inactive while the CPU
  // is still held in reset.
  always_comb begin
    ipl_d  = ipl_q;
    act_d  = act_q;
`ifdef IPL_FILTER_EN
    samp_d = samp_q;
`endif
    if (!cpu_run) begin
      ipl_d  = 3'b111;
      act_d  = 3'd0;
`ifdef IPL_FILTER_EN
      samp_d = 3'd0;
`endif
    end else if (cep) begin
`ifdef IPL_FILTER_EN
      // The new level is accepted only when it matches the previous sample.
      samp_d = lvl;
      if (lvl == samp_q) begin
        ipl_d = ~lvl;
        act_d = win;
      end
`else
      ipl_d = ~lvl;
      act_d = win;
`endif
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= RST_CYCLES;
      sync1_q <= '1;
      sync2_q <= '1;
      sdly_q  <= '0;
      pend_q  <= '0;
      ipl_q   <= 3'b111;
      act_q   <= 3'd0;
`ifdef IPL_FILTER_EN
      samp_q  <= 3'd0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      sync1_q <= _irq_src;
      sync2_q <= sync1_q;
      sdly_q  <= s;
      pend_q  <= pend_d;
      ipl_q   <= ipl_d;
      act_q   <= act_d;
`ifdef IPL_FILTER_EN
      samp_q  <= samp_d;
`endif
    end
  end

endmodule
